// File: rtl/mem_ctrl_pkg.sv
// rtl/mem_ctrl_pkg.sv - shared constants, state encoding and helpers for mem_ctrl
//
// Purpose: reset level, zero word, FSM state encoding, load/store funct3 codes
//          and the funct3 -> byte count helper used by mem_ctrl.
// Ports:   none (package).

package mem_ctrl_pkg;

    localparam logic        RST_ENABLE = 1'b0;
    localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Transfer length in bytes; only funct3[1:0] selects the width.
    function automatic logic [2:0] xfer_len(input logic [2:0] funct3);
        logic [2:0] w_len;
        case (funct3[1:0])
            F3_SB[1:0]: w_len = 3'd1;
            F3_SH[1:0]: w_len = 3'd2;
            default:    w_len = 3'd4;
        endcase
        return w_len;
    endfunction

endpackage

// File: rtl/mem_ld_ext.sv
// rtl/mem_ld_ext.sv - little-endian byte assembly with load sign/zero extension
//
// Purpose: combines four bytes (b0 = lowest address) into a 32-bit word and
//          applies the load extension selected by funct3.
// Ports:   i_b0..i_b3 - bytes in address order
//          i_funct3   - load type (LB/LH/LW/LBU/LHU)
//          o_data     - extended 32-bit load result

module mem_ld_ext
    import mem_ctrl_pkg::*;
(
    input  logic [7:0]  i_b0,
    input  logic [7:0]  i_b1,
    input  logic [7:0]  i_b2,
    input  logic [7:0]  i_b3,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    always_comb begin
        o_data = {i_b3, i_b2, i_b1, i_b0};
        case (i_funct3)
            F3_LB:   o_data = {{24{i_b0[7]}}, i_b0};
            F3_LH:   o_data = {{16{i_b1[7]}}, i_b1, i_b0};
            F3_LBU:  o_data = {24'h0, i_b0};
            F3_LHU:  o_data = {16'h0, i_b1, i_b0};
            default: o_data = {i_b3, i_b2, i_b1, i_b0};
        endcase
    end

endmodule

// File: rtl/mem_ctrl.sv
// rtl/mem_ctrl.sv - IF/MEM arbiter and byte-serial sequencer for an 8-bit sync RAM
//
// Purpose: accepts one fetch or load/store at a time (MEM has fixed priority),
//          moves it one byte per cycle little-endian over the RAM bus, returns
//          assembled fetch/load data and raises pipeline stall requests.
// Ports:   clk, rst (sync, active-low)
//          if_req/if_addr/if_cancel               - fetch requester
//          mem_req/mem_we/mem_funct3/mem_addr/mem_wdata - load/store requester
//          if_done/if_inst, mem_done/mem_rdata    - completion pulses and data
//          stallreq_if/stallreq_mem               - stall requests to ctrl
//          ram_din, ram_dout/ram_a/ram_wr         - external RAM bus

module mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [ADDR_WIDTH-1:0] if_addr,
    input  logic                  if_cancel,
    input  logic                  mem_req,
    input  logic                  mem_we,
    input  logic [2:0]            mem_funct3,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [31:0]           mem_wdata,
    output logic                  if_done,
    output logic [31:0]           if_inst,
    output logic                  mem_done,
    output logic [31:0]           mem_rdata,
    output logic                  stallreq_if,
    output logic                  stallreq_mem,
    input  logic [7:0]            ram_din,
    output logic [7:0]            ram_dout,
    output logic [ADDR_WIDTH-1:0] ram_a,
    output logic                  ram_wr
);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [2:0]            r_cnt;
    logic [2:0]            r_len;
    logic                  r_is_if;
    logic [2:0]            r_funct3;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [31:0]           r_wdata;
    logic [7:0]            r_b0;
    logic [7:0]            r_b1;
    logic [7:0]            r_b2;
    logic                  r_if_done;
    logic                  r_mem_done;
    logic [31:0]           r_if_inst;
    logic [31:0]           r_mem_rdata;
    logic [7:0]            r_ram_dout;
    logic [ADDR_WIDTH-1:0] r_ram_a;
    logic                  r_ram_wr;

    logic                  w_accept_mem;
    logic                  w_accept_if;
    logic                  w_cancel;
    logic                  w_rd_last;
    logic                  w_wr_last;
    logic [7:0]            w_b0;
    logic [7:0]            w_b1;
    logic [31:0]           w_ld_data;
    logic [7:0]            w_wr_byte;
    logic [ADDR_WIDTH-1:0] w_addr_k;

    assign w_cancel  = r_is_if && if_cancel;
    // Counter holds k for edge E(k); E(0) is the accept edge.
    assign w_rd_last = (r_cnt == r_len + 3'd1);
    assign w_wr_last = (r_cnt == r_len);
    assign w_addr_k  = r_base + ADDR_WIDTH'(r_cnt);

    // The final byte is still on ram_din at the completion edge, so it is
    // taken directly instead of from a capture register.
    assign w_b0 = (r_len == 3'd1) ? ram_din : r_b0;
    assign w_b1 = (r_len == 3'd2) ? ram_din : r_b1;

    always_comb begin
        w_wr_byte = r_wdata[7:0];
        case (r_cnt[1:0])
            2'd1:    w_wr_byte = r_wdata[15:8];
            2'd2:    w_wr_byte = r_wdata[23:16];
            2'd3:    w_wr_byte = r_wdata[31:24];
            default: w_wr_byte = r_wdata[7:0];
        endcase
    end

    mem_ld_ext u_ld_ext (
        .i_b0     (w_b0),
        .i_b1     (w_b1),
        .i_b2     (r_b2),
        .i_b3     (ram_din),
        .i_funct3 (r_funct3),
        .o_data   (w_ld_data)
    );

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_accept_mem = 1'b0;
        w_accept_if  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (mem_req) begin
                    w_accept_mem = 1'b1;
                    w_state_nxt  = mem_we ? ST_WRITE : ST_READ;
                end else if (if_req && !if_cancel) begin
                    w_accept_if = 1'b1;
                    w_state_nxt = ST_READ;
                end
            end
            ST_READ: begin
                if (w_cancel) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_rd_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_WRITE: begin
                if (w_wr_last) begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            r_cnt       <= 3'd0;
            r_len       <= 3'd0;
            r_is_if     <= 1'b0;
            r_funct3    <= 3'd0;
            r_base      <= '0;
            r_wdata     <= ZERO_WORD;
            r_b0        <= 8'h00;
            r_b1        <= 8'h00;
            r_b2        <= 8'h00;
            r_if_done   <= 1'b0;
            r_mem_done  <= 1'b0;
            r_if_inst   <= ZERO_WORD;
            r_mem_rdata <= ZERO_WORD;
            r_ram_dout  <= 8'h00;
            r_ram_a     <= '0;
            r_ram_wr    <= 1'b0;
        end else begin
            r_if_done  <= 1'b0;
            r_mem_done <= 1'b0;
            r_ram_wr   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept_mem) begin
                        r_cnt    <= 3'd1;
                        r_len    <= xfer_len(mem_funct3);
                        r_is_if  <= 1'b0;
                        r_funct3 <= mem_funct3;
                        r_base   <= mem_addr;
                        r_wdata  <= mem_wdata;
                        r_ram_a  <= mem_addr;
                        if (mem_we) begin
                            r_ram_dout <= mem_wdata[7:0];
                            r_ram_wr   <= 1'b1;
                        end
                    end else if (w_accept_if) begin
                        r_cnt    <= 3'd1;
                        r_len    <= 3'd4;
                        r_is_if  <= 1'b1;
                        r_funct3 <= F3_LW;
                        r_base   <= if_addr;
                        r_ram_a  <= if_addr;
                    end
                end
                ST_READ: begin
                    if (!w_cancel) begin
                        r_cnt <= r_cnt + 3'd1;
                        if (r_cnt < r_len) begin
                            r_ram_a <= w_addr_k;
                        end
                        // Byte k arrives two edges after its address edge.
                        if (r_cnt >= 3'd2 && r_cnt <= r_len) begin
                            case (r_cnt)
                                3'd2:    r_b0 <= ram_din;
                                3'd3:    r_b1 <= ram_din;
                                3'd4:    r_b2 <= ram_din;
                                default: ;
                            endcase
                        end
                        if (w_rd_last) begin
                            if (r_is_if) begin
                                r_if_done <= 1'b1;
                                r_if_inst <= w_ld_data;
                            end else begin
                                r_mem_done  <= 1'b1;
                                r_mem_rdata <= w_ld_data;
                            end
                        end
                    end
                end
                ST_WRITE: begin
                    r_cnt <= r_cnt + 3'd1;
                    if (w_wr_last) begin
                        r_mem_done <= 1'b1;
                    end else begin
                        r_ram_a    <= w_addr_k;
                        r_ram_dout <= w_wr_byte;
                        r_ram_wr   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign if_done      = r_if_done;
    assign if_inst      = r_if_inst;
    assign mem_done     = r_mem_done;
    assign mem_rdata    = r_mem_rdata;
    assign ram_dout     = r_ram_dout;
    assign ram_a        = r_ram_a;
    assign ram_wr       = r_ram_wr;
    assign stallreq_if  = if_req && !r_if_done;
    assign stallreq_mem = mem_req && !r_mem_done;

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Single-port memory controller shared by instruction fetch (IF) and load/store (MEM) over the external 8-bit synchronous RAM bus.
- Arbitrates between the two requesters and sequences multi-byte transfers one byte per cycle, little-endian.
- Returns assembled instruction and load data.
- Raises stall requests to ctrl, which holds the pipeline registers (including id_ex via stall_sign) while a transfer is outstanding.

Parameters:
- ADDR_WIDTH, 32, width of all address ports.

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock; reset is synchronous and active-low (rst==0 resets on posedge clk).
- if_req  in  1  IF fetch request; level, held until if_done.
- if_addr  in  ADDR_WIDTH  fetch address (pc).
- if_cancel  in  1  branch flush; aborts a pending or in-flight fetch.
- mem_req  in  1  load/store request; level, held until mem_done.
- mem_we  in  1  1 = store, 0 = load.
- mem_funct3  in  3  LB=000 LH=001 LW=010 LBU=100 LHU=101 SB=000 SH=001 SW=010.
- mem_addr  in  ADDR_WIDTH  load/store address.
- mem_wdata  in  32  store data.
- if_done  out  1  one-cycle pulse; if_inst valid.
- if_inst  out  32  fetched instruction.
- mem_done  out  1  one-cycle pulse; mem_rdata valid for loads.
- mem_rdata  out  32  extended load data.
- stallreq_if  out  1  if_req && !if_done (combinational).
- stallreq_mem  out  1  mem_req && !mem_done (combinational).
- ram_din  in  8  RAM read byte, valid the cycle after the address edge.
- ram_dout  out  8  RAM write byte (registered).
- ram_a  out  ADDR_WIDTH  RAM byte address (registered).
- ram_wr  out  1  RAM write enable (registered).

Behaviour:
- Reset: state IDLE, counters 0, ram_a=0, ram_dout=0, ram_wr=0, if_done=0, mem_done=0, if_inst=0, mem_rdata=0.
- Reset mid-transfer: abandon at once; no done pulse; ram_wr=0 after the edge.
- States and transitions:
  - IDLE: if mem_req, accept MEM (fixed priority); else accept IF if if_req && !if_cancel.
    - Accept latches base address, byte count N (1/2/4 from funct3[1:0]; IF always 4), op, funct3 and wdata.
    - Transitions to READ or WRITE.
  - READ:
    - Edge E(k), k=0..N-1, registers ram_a=base+k.
    - Byte k is captured from ram_din at E(k+2).
    - At E(N+1): registers done=1 and the data; state goes to DONE.
    - Latency from accept edge to done-high cycle: N+1 (word = 5 cycles).
  - WRITE:
    - Edge E(k) registers ram_a=base+k, ram_dout=wdata[8k+7:8k], ram_wr=1, for k=0..N-1.
    - At E(N): ram_wr=0, done=1; state goes to DONE.
    - Latency: N cycles (SW = 4, SB = 1).
  - DONE: done pulse cycle. Requester drops req at the edge ending this cycle. Unconditional return to IDLE, so there is one turnaround cycle and no re-accept of the same request.
- Load extension:
  - LB/LH sign-extend from bit 7/15.
  - LBU/LHU zero-extend.
  - LW passes through.
- Address arithmetic: base+k wraps modulo 2^ADDR_WIDTH. No alignment check; a misaligned word is read byte-wise as normal.
- if_cancel:
  - In IDLE: suppresses IF accept that cycle.
  - During an IF READ: return to IDLE at the next edge, no if_done, if_inst unchanged.
  - During a MEM transfer: ignored.
- Simultaneous if_req and mem_req in IDLE: MEM wins. IF is served after MEM's DONE cycle.
- A MEM transfer is never preempted. IF requests arriving during MEM simply wait.
- The outputs if_done and mem_done are never high together.
- ram_wr is never 1 outside WRITE.

Decomposition:
- Shared defines file:
  - `RstEnable` = 1'b0 for this block.
  - State encodings: IDLE/READ/WRITE/DONE.
  - funct3 load/store constants.
  - `ZeroWord`.
- One natural sub-module: mem_ld_ext. It is combinational byte assembly plus sign/zero extension (4 byte regs + funct3 -> 32-bit word), reused by any future cache.

Test Plan:
- IF word fetch: if_req=1, if_addr=0x100, RAM[0x100..0x103]=13,05,A0,00 -> ram_a steps 0x100..0x103, if_done high exactly 5 cycles after accept, if_inst=0x00A00513.
- LB sign: mem_req, funct3=000, RAM[0x2000]=0x80 -> mem_done 2 cycles after accept, mem_rdata=0xFFFFFF80. Same with LBU -> 0x00000080.
- SW: mem_we=1, funct3=010, addr=0x3000, wdata=0xDEADBEEF -> ram_wr=1 for 4 consecutive cycles with bytes EF,BE,AD,DE at 0x3000..0x3003; mem_done in cycle 4.
- Contention: if_req and mem_req (LH, addr 0x10, RAM=34,12) rise together -> MEM served first, mem_rdata=0x00001234. stallreq_if stays 1 throughout; IF accepted 1 cycle after mem_done.
- Cancel: if_cancel pulsed 2 cycles into an IF read -> no if_done, FSM IDLE next cycle, a pending mem_req is accepted the following cycle.
- Reset mid-SW: rst=0 after byte 1 -> ram_wr=0 and all outputs zero after the edge; no mem_done pulse.
